host_mem_loader: RTL and testbench
==================================

// Module: host_mem_loader
// PURPOSE
//   Host-side command responder for the lisp core. Accepts WRITE/READ/CLEAR/RUN commands
//   on a valid/ready stream; owns the shared heap memory port while the core is idle.
//   Loads expressions, pulses core start, waits for Halt/Error, returns val or error code.
//   Sits between the board/host link and core + heap memory; one response per command.
// PARAMETERS
//   ADDR_W        8      heap address width (2^ADDR_W = 256 words)
//   DATA_W        16     heap word / tagged-value width
//   TIMEOUT_CYC   65535  max cycles to wait for core Halt/Error after start (>=4)
// PORTS
//   clk            in   1       system clock; all logic on rising edge
//   rst_n          in   1       asynchronous active-low reset
//   cmd_valid      in   1       command present
//   cmd_ready      out  1       loader accepts command (IDLE only)
//   cmd_op         in   2       00 WRITE, 01 READ, 10 RUN, 11 CLEAR
//   cmd_addr       in   ADDR_W  heap address (WRITE/READ)
//   cmd_data       in   DATA_W  write data (WRITE) or expression (RUN)
//   rsp_valid      out  1       response present; held until rsp_ready
//   rsp_ready      in   1       host accepts response
//   rsp_data       out  DATA_W  read data / core val / core error code
//   rsp_status     out  2       00 OK, 01 CORE_ERROR, 10 TIMEOUT
//   mem_owner      out  1       1 = loader drives heap port, 0 = core drives it
//   mem_we         out  1       heap write enable
//   mem_addr       out  ADDR_W  heap address
//   mem_wdata      out  DATA_W  heap write data
//   mem_rdata      in   DATA_W  heap read data, valid 1 cycle after mem_addr
//   core_expr      out  DATA_W  expression to evaluate, stable for whole RUN
//   core_start     out  1       one-cycle start pulse
//   core_halted    in   1       core in Halt
//   core_error     in   1       core in Error
//   core_val       in   DATA_W  result value (valid while halted)
//   core_err_code  in   DATA_W  error code (valid while error)
// BEHAVIOUR
//   Reset: state IDLE; cmd_ready=1 (comb. from IDLE), rsp_valid=0, rsp_data=0,
//     rsp_status=00, mem_owner=1, mem_we=0, mem_addr=0, mem_wdata=0, core_expr=0, core_start=0.
//   States: IDLE, WRITE, RD_ADDR, RD_DATA, CLEAR, START, WAIT, RESP.
//   Handshake: command taken on cmd_valid&&cmd_ready; fields latched that cycle.
//     Response transfers on rsp_valid&&rsp_ready, then IDLE (ready next cycle).
//     rsp_data/rsp_status stable while rsp_valid && !rsp_ready.
//   WRITE: 1 cycle mem_we=1 at cmd_addr/cmd_data -> RESP, rsp_data=cmd_data, OK.
//   READ: RD_ADDR drives addr, RD_DATA samples mem_rdata -> RESP, OK.
//   CLEAR: mem_we=1, wdata=0, addr 0..2^ADDR_W-1 one per cycle (256 cycles), then
//     RESP, rsp_data=0, OK. Counter is ADDR_W+1 bits; no wrap back to 0.
//   RUN: core_expr<=cmd_data; START: core_start=1 for exactly 1 cycle, mem_owner=0.
//     WAIT: halted/error ignored in the START cycle and the first WAIT cycle (stale Halt
//     from previous run); sampled from the 2nd WAIT cycle onward.
//     halted -> rsp_data=core_val, OK. error -> rsp_data=core_err_code, CORE_ERROR.
//     Both high same cycle -> error wins. Timeout counter starts at START;
//     at TIMEOUT_CYC cycles with no done -> rsp_data=0, TIMEOUT.
//     mem_owner returns to 1 on entering RESP; after TIMEOUT the core may still be
//     running; host must assert rst_n before trusting heap contents.
//   mem_we only ever 1 in WRITE/CLEAR; never while mem_owner=0.
//   rst_n low mid-operation (incl. mid-CLEAR or WAIT): immediate return to reset values;
//     pending command/response discarded, no response emitted.
// TESTING
//   WRITE addr 0x01 data 0xDEAD, then READ 0x01 -> both OK, READ rsp_data=0xDEAD.
//   Write mem[1]=BEEF,[2]=DEAD,[3]=0001,[4]=0002; RUN 0x1004, core model halts val=0x1004
//     after 20 cycles -> core_start 1 pulse, mem_owner=0 during run, rsp OK 0x1004.
//   Core model holds stale halted=1 at start, drops next cycle, re-halts val=0xDEAD -> OK
//     0xDEAD (not the stale val).
//   Core model asserts halted and error together, err_code=0x0003 -> CORE_ERROR, 0x0003.
//   TIMEOUT_CYC=16, core never finishes -> TIMEOUT, rsp_data=0, 16 cycles after START.
//   CLEAR after filling 0xFF..0x00 -> 256 writes, OK; READ 0xFF -> 0; rsp_ready low 10
//     cycles -> rsp_valid/data stable; rst_n pulse mid-CLEAR -> no response, outputs reset.

Source files
------------

// File: rtl/host_mem_loader.sv
// host_mem_loader: host-side command responder for the lisp core.
// Takes WRITE/READ/RUN/CLEAR commands on a valid/ready stream, owns the heap
// port while the core is idle, runs the core and returns one response per command.
module host_mem_loader #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 16,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [1:0]        rsp_status,
    output logic              mem_owner,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] core_expr,
    output logic              core_start,
    input  logic              core_halted,
    input  logic              core_error,
    input  logic [DATA_W-1:0] core_val,
    input  logic [DATA_W-1:0] core_err_code
);

    localparam int CNT_W = ADDR_W + 1;
    localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_RUN   = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_CORE_ERR = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WRITE   = 3'd1,
        S_RD_ADDR = 3'd2,
        S_RD_DATA = 3'd3,
        S_CLEAR   = 3'd4,
        S_START   = 3'd5,
        S_WAIT    = 3'd6,
        S_RESP    = 3'd7
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic                r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_data;
    logic [1:0]          r_rsp_status;
    logic                r_mem_owner;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic [DATA_W-1:0]   r_core_expr;
    logic                r_core_start;
    logic [CNT_W-1:0]    r_clr_cnt;
    logic [TO_W-1:0]     r_to_cnt;

    logic                w_cmd_fire;
    logic [CNT_W-1:0]    w_clr_next;
    logic                w_clr_done;
    logic                w_core_done;
    logic                w_timeout;

    assign cmd_ready  = (r_state == S_IDLE);
    assign w_cmd_fire = cmd_valid && (r_state == S_IDLE);
    assign w_clr_next = r_clr_cnt + CNT_W'(1);
    // Top counter bit set means every address has been written once.
    assign w_clr_done = w_clr_next[ADDR_W];
    // Halt/Error from the previous run can still be up during START and the
    // first WAIT cycle, so only trust them once the counter has reached 2.
    assign w_core_done = (r_to_cnt >= TO_W'(2)) && (core_halted || core_error);
    assign w_timeout   = (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));

    assign rsp_valid  = r_rsp_valid;
    assign rsp_data   = r_rsp_data;
    assign rsp_status = r_rsp_status;
    assign mem_owner  = r_mem_owner;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign core_expr  = r_core_expr;
    assign core_start = r_core_start;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_cmd_fire) begin
                    case (cmd_op)
                        OP_WRITE: w_next_state = S_WRITE;
                        OP_READ:  w_next_state = S_RD_ADDR;
                        OP_RUN:   w_next_state = S_START;
                        OP_CLEAR: w_next_state = S_CLEAR;
                        default:  w_next_state = S_IDLE;
                    endcase
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_WRITE:   w_next_state = S_RESP;
            S_RD_ADDR: w_next_state = S_RD_DATA;
            S_RD_DATA: w_next_state = S_RESP;
            S_CLEAR: begin
                if (w_clr_done) begin
                    w_next_state = S_RESP;
                end else begin
                    w_next_state = S_CLEAR;
                end
            end
            S_START:   w_next_state = S_WAIT;
            S_WAIT: begin
                if (w_core_done || w_timeout) begin
                    w_next_state = S_RESP;
                end else begin
                    w_next_state = S_WAIT;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_next_state = S_RESP;
                end
            end
            default:   w_next_state = S_IDLE;
        endcase
    end

    // Registered outputs, heap port, clear and timeout counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid  <= 1'b0;
            r_rsp_data   <= '0;
            r_rsp_status <= ST_OK;
            r_mem_owner  <= 1'b1;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_core_expr  <= '0;
            r_core_start <= 1'b0;
            r_clr_cnt    <= '0;
            r_to_cnt     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_cmd_fire) begin
                        case (cmd_op)
                            OP_WRITE: begin
                                r_mem_we    <= 1'b1;
                                r_mem_addr  <= cmd_addr;
                                r_mem_wdata <= cmd_data;
                            end
                            OP_READ: begin
                                r_mem_addr <= cmd_addr;
                            end
                            OP_RUN: begin
                                r_core_expr  <= cmd_data;
                                r_core_start <= 1'b1;
                                r_mem_owner  <= 1'b0;
                                r_to_cnt     <= '0;
                            end
                            OP_CLEAR: begin
                                r_clr_cnt   <= '0;
                                r_mem_we    <= 1'b1;
                                r_mem_addr  <= '0;
                                r_mem_wdata <= '0;
                            end
                            default: begin
                                r_mem_we <= 1'b0;
                            end
                        endcase
                    end
                end
                S_WRITE: begin
                    r_mem_we     <= 1'b0;
                    r_rsp_valid  <= 1'b1;
                    r_rsp_data   <= r_mem_wdata;
                    r_rsp_status <= ST_OK;
                end
                S_RD_ADDR: begin
                    r_mem_we <= 1'b0;
                end
                S_RD_DATA: begin
                    r_rsp_valid  <= 1'b1;
                    r_rsp_data   <= mem_rdata;
                    r_rsp_status <= ST_OK;
                end
                S_CLEAR: begin
                    if (w_clr_done) begin
                        r_mem_we     <= 1'b0;
                        r_rsp_valid  <= 1'b1;
                        r_rsp_data   <= '0;
                        r_rsp_status <= ST_OK;
                    end else begin
                        r_clr_cnt  <= w_clr_next;
                        r_mem_addr <= w_clr_next[ADDR_W-1:0];
                    end
                end
                S_START: begin
                    r_core_start <= 1'b0;
                    r_to_cnt     <= r_to_cnt + TO_W'(1);
                end
                S_WAIT: begin
                    if (w_core_done) begin
                        r_mem_owner <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        // Error outranks Halt when both are raised together.
                        if (core_error) begin
                            r_rsp_data   <= core_err_code;
                            r_rsp_status <= ST_CORE_ERR;
                        end else begin
                            r_rsp_data   <= core_val;
                            r_rsp_status <= ST_OK;
                        end
                    end else if (w_timeout) begin
                        r_mem_owner  <= 1'b1;
                        r_rsp_valid  <= 1'b1;
                        r_rsp_data   <= '0;
                        r_rsp_status <= ST_TIMEOUT;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    r_mem_we <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_host_mem_loader.sv
// Self-checking bench for host_mem_loader: table of WRITE/READ vectors, then
// directed RUN, stale-halt, error, timeout, CLEAR, stall and reset sequences.
module tb_host_mem_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_valid2;
    logic        cmd_ready, cmd_ready2;
    logic [1:0]  cmd_op;
    logic [7:0]  cmd_addr;
    logic [15:0] cmd_data;
    logic        rsp_valid, rsp_valid2;
    logic        rsp_ready, rsp_ready2;
    logic [15:0] rsp_data, rsp_data2;
    logic [1:0]  rsp_status, rsp_status2;
    logic        mem_owner, mem_owner2;
    logic        mem_we, mem_we2;
    logic [7:0]  mem_addr, mem_addr2;
    logic [15:0] mem_wdata, mem_wdata2;
    logic [15:0] mem_rdata;
    logic [15:0] core_expr, core_expr2;
    logic        core_start, core_start2;
    logic        core_halted, core_error;
    logic [15:0] core_val, core_err_code;

    logic [15:0] mem [0:255];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    // Monitor counters (only ever incremented here).
    int mon_start = 0, mon_owner_low = 0, mon_we = 0, mon_we_bad = 0, mon_seq_bad = 0;
    logic        prev_we = 1'b0;
    logic [7:0]  prev_addr = 8'h00;

    host_mem_loader #(.ADDR_W(8), .DATA_W(16), .TIMEOUT_CYC(65535)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_status(rsp_status), .mem_owner(mem_owner), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .core_expr(core_expr), .core_start(core_start), .core_halted(core_halted),
        .core_error(core_error), .core_val(core_val), .core_err_code(core_err_code)
    );

    host_mem_loader #(.ADDR_W(8), .DATA_W(16), .TIMEOUT_CYC(16)) dut_to (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2),
        .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2), .rsp_data(rsp_data2),
        .rsp_status(rsp_status2), .mem_owner(mem_owner2), .mem_we(mem_we2),
        .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .mem_rdata(16'h0000),
        .core_expr(core_expr2), .core_start(core_start2), .core_halted(1'b0),
        .core_error(1'b0), .core_val(16'h0000), .core_err_code(16'h0000)
    );

    always #5 clk = ~clk;

    // Cycle counter.
    always @(posedge clk) cyc <= cyc + 1;

    // Heap model: synchronous write, read data one cycle after address.
    always @(posedge clk) begin
        if (mem_we && mem_owner) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    // Port monitor sampled away from the active edge.
    always @(negedge clk) begin
        if (core_start) mon_start <= mon_start + 1;
        if (!mem_owner) mon_owner_low <= mon_owner_low + 1;
        if (mem_we) mon_we <= mon_we + 1;
        if (mem_we && !mem_owner) mon_we_bad <= mon_we_bad + 1;
        if (mem_we && prev_we && (mem_addr != prev_addr + 8'd1)) mon_seq_bad <= mon_seq_bad + 1;
        prev_we   <= mem_we;
        prev_addr <= mem_addr;
    end

    typedef struct {
        logic [1:0]  op;
        logic [7:0]  addr;
        logic [15:0] data;
        logic [15:0] exp_data;
        logic [1:0]  exp_status;
    } vec_t;
    vec_t vecs [0:9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [7:0] addr, input logic [15:0] data);
        int n;
        n = 0;
        @(posedge clk); #1;
        cmd_op = op; cmd_addr = addr; cmd_data = data; cmd_valid = 1'b1;
        while (!cmd_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("cmd_accept", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic get_rsp(output logic [15:0] d, output logic [1:0] s);
        int n;
        n = 0;
        while (!rsp_valid && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        check("rsp_arrive", 32'(rsp_valid), 32'd1);
        d = rsp_data;
        s = rsp_status;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic wait_start();
        int n;
        n = 0;
        while (!core_start && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("core_start_seen", 32'(core_start), 32'd1);
    endtask

    logic [15:0] d;
    logic [1:0]  s;
    int          snap_start, snap_owner, snap_we, snap_seq, snap_bad, t0, n, errs, seen;
    logic [15:0] hold_d;
    logic [1:0]  hold_s;

    initial begin
        vecs[0] = '{2'b00, 8'h01, 16'hDEAD, 16'hDEAD, 2'b00};
        vecs[1] = '{2'b01, 8'h01, 16'h0000, 16'hDEAD, 2'b00};
        vecs[2] = '{2'b00, 8'h01, 16'hBEEF, 16'hBEEF, 2'b00};
        vecs[3] = '{2'b00, 8'h02, 16'hDEAD, 16'hDEAD, 2'b00};
        vecs[4] = '{2'b00, 8'h03, 16'h0001, 16'h0001, 2'b00};
        vecs[5] = '{2'b00, 8'h04, 16'h0002, 16'h0002, 2'b00};
        vecs[6] = '{2'b01, 8'h01, 16'h0000, 16'hBEEF, 2'b00};
        vecs[7] = '{2'b01, 8'h04, 16'h0000, 16'h0002, 2'b00};
        vecs[8] = '{2'b00, 8'hFF, 16'h1234, 16'h1234, 2'b00};
        vecs[9] = '{2'b01, 8'hFF, 16'h0000, 16'h1234, 2'b00};

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_valid2 = 1'b0; rsp_ready = 1'b0; rsp_ready2 = 1'b0;
        cmd_op = 2'b00; cmd_addr = 8'h00; cmd_data = 16'h0000;
        core_halted = 1'b0; core_error = 1'b0; core_val = 16'h0000; core_err_code = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        check("rst_mem_owner", 32'(mem_owner), 32'd1);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_core_start", 32'(core_start), 32'd0);
        rst_n = 1'b1;

        // Table-driven WRITE/READ vectors.
        for (int i = 0; i < 10; i++) begin
            send_cmd(vecs[i].op, vecs[i].addr, vecs[i].data);
            get_rsp(d, s);
            check($sformatf("vec%0d_data", i), 32'(d), 32'(vecs[i].exp_data));
            check($sformatf("vec%0d_status", i), 32'(s), 32'(vecs[i].exp_status));
        end

        // RUN: core halts 20 cycles after start with val 0x1004.
        snap_start = mon_start; snap_owner = mon_owner_low; snap_bad = mon_we_bad;
        fork
            begin send_cmd(2'b10, 8'h00, 16'h1004); get_rsp(d, s); end
            begin
                wait_start();
                repeat (20) @(posedge clk);
                #1;
                check("run_core_expr", 32'(core_expr), 32'h1004);
                core_val = 16'h1004; core_halted = 1'b1;
            end
        join
        check("run_data", 32'(d), 32'h1004);
        check("run_status", 32'(s), 32'd0);
        check("run_start_pulses", 32'(mon_start - snap_start), 32'd1);
        check("run_owner_low", 32'(mon_owner_low - snap_owner > 20), 32'd1);
        check("run_owner_back", 32'(mem_owner), 32'd1);

        // RUN with stale halt still up from the previous run.
        fork
            begin send_cmd(2'b10, 8'h00, 16'h2002); get_rsp(d, s); end
            begin
                wait_start();
                @(posedge clk); #1;
                core_halted = 1'b0;
                repeat (5) @(posedge clk);
                #1;
                core_val = 16'hDEAD; core_halted = 1'b1;
            end
        join
        check("stale_data", 32'(d), 32'hDEAD);
        check("stale_status", 32'(s), 32'd0);
        core_halted = 1'b0;

        // RUN where halt and error rise together: error wins.
        fork
            begin send_cmd(2'b10, 8'h00, 16'h3003); get_rsp(d, s); end
            begin
                wait_start();
                repeat (5) @(posedge clk);
                #1;
                core_val = 16'h5555; core_err_code = 16'h0003;
                core_halted = 1'b1; core_error = 1'b1;
            end
        join
        check("err_data", 32'(d), 32'h0003);
        check("err_status", 32'(s), 32'd1);
        check("no_we_while_core", 32'(mon_we_bad - snap_bad), 32'd0);
        core_halted = 1'b0; core_error = 1'b0;

        // TIMEOUT on the short-timeout instance whose core never finishes.
        @(posedge clk); #1;
        cmd_op = 2'b10; cmd_data = 16'h0042; cmd_valid2 = 1'b1;
        check("to_cmd_ready", 32'(cmd_ready2), 32'd1);
        @(posedge clk); #1;
        cmd_valid2 = 1'b0;
        check("to_start", 32'(core_start2), 32'd1);
        check("to_owner_low", 32'(mem_owner2), 32'd0);
        t0 = cyc; n = 0;
        while (!rsp_valid2 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("to_latency", 32'(cyc - t0), 32'd16);
        check("to_data", 32'(rsp_data2), 32'd0);
        check("to_status", 32'(rsp_status2), 32'd2);
        check("to_owner_back", 32'(mem_owner2 && !mem_we2), 32'd1);
        rsp_ready2 = 1'b1;
        @(posedge clk); #1;
        rsp_ready2 = 1'b0;

        // Fill the heap with 0xFF..0x00, then CLEAR.
        errs = 0;
        for (int i = 0; i < 256; i++) begin
            send_cmd(2'b00, 8'(i), 16'(8'hFF - 8'(i)));
            get_rsp(d, s);
            if (s != 2'b00 || d != 16'(8'hFF - 8'(i))) errs++;
        end
        check("fill_errors", 32'(errs), 32'd0);
        snap_we = mon_we; snap_seq = mon_seq_bad;
        send_cmd(2'b11, 8'h00, 16'h0000);
        get_rsp(d, s);
        check("clr_data", 32'(d), 32'd0);
        check("clr_status", 32'(s), 32'd0);
        check("clr_we_count", 32'(mon_we - snap_we), 32'd256);
        check("clr_addr_seq", 32'(mon_seq_bad - snap_seq), 32'd0);
        errs = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== 16'h0000) errs++;
        check("clr_heap_zero", 32'(errs), 32'd0);
        send_cmd(2'b01, 8'hFF, 16'h0000);
        get_rsp(d, s);
        check("clr_read_ff", 32'(d), 32'd0);

        // Response held with rsp_ready low for 10 cycles.
        send_cmd(2'b00, 8'hA5, 16'h5A5A);
        get_rsp(d, s);
        send_cmd(2'b01, 8'hA5, 16'h0000);
        n = 0;
        while (!rsp_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        hold_d = rsp_data; hold_s = rsp_status; errs = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (!rsp_valid || rsp_data !== hold_d || rsp_status !== hold_s || cmd_ready) errs++;
        end
        check("stall_stable", 32'(errs), 32'd0);
        check("stall_data", 32'(hold_d), 32'h5A5A);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("stall_release", 32'(rsp_valid), 32'd0);

        // Reset pulse in the middle of a CLEAR.
        send_cmd(2'b11, 8'h00, 16'h0000);
        repeat (50) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_mem_we", 32'(mem_we), 32'd0);
        check("mid_rst_mem_addr", 32'(mem_addr), 32'd0);
        check("mid_rst_mem_owner", 32'(mem_owner), 32'd1);
        check("mid_rst_core_expr", 32'(core_expr), 32'd0);
        check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        repeat (300) begin
            @(posedge clk); #1;
            if (rsp_valid || mem_we) seen++;
        end
        check("mid_rst_no_rsp", 32'(seen), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
